// File: rtl/pulse_width_decoder.sv
// Measures the width of each high pulse on a synchronous level input and
// publishes accepted widths through a one-entry valid/ready result register.
`timescale 1ns/1ps

module pulse_width_decoder #(
    parameter int CNT_W     = 8,
    parameter int MIN_WIDTH = 2,
    parameter int MAX_WIDTH = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_pulse,
    input  logic             out_ready,
    output logic [CNT_W-1:0] width_data,
    output logic             out_valid,
    output logic             err_short,
    output logic             err_long,
    output logic             overrun,
    output logic             busy
);

    // Handshake: a result moves to the consumer on any rising edge where
    // out_valid and out_ready are both 1; width_data is stable until then.

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEASURE  = 2'd1,
        OVERLONG = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WIDTH);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             in_prev;
    logic             rise;
    logic             publish;
    logic             slot_free;

    assign rise      = in_pulse & ~in_prev;
    assign publish   = (state == MEASURE) && !in_pulse && (count >= MIN_C);
    // The slot can take a new width if empty or being drained this same edge.
    assign slot_free = !out_valid || out_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            // Starts high so a level already asserted at release is not a rise.
            in_prev    <= 1'b1;
            width_data <= '0;
            out_valid  <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            in_prev   <= in_pulse;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            overrun   <= 1'b0;

            if (publish) begin
                if (slot_free) begin
                    width_data <= count;
                    out_valid  <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= MEASURE;
                        count <= CNT_W'(1);
                    end
                end
                MEASURE: begin
                    if (in_pulse) begin
                        if (count == MAX_C) begin
                            state    <= OVERLONG;
                            err_long <= 1'b1;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end else begin
                        if (count < MIN_C) begin
                            err_short <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                OVERLONG: begin
                    if (!in_pulse) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Bench for pulse_width_decoder: vector table plus hand-written sequences for
// latency, overlong, backpressure and reset behaviour.
`timescale 1ns/1ps

module tb_pulse_width_decoder;
    localparam int CNT_W = 8;
    localparam int MIN_W = 2;
    localparam int MAX_W = 200;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_pulse = 1'b1;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] width_data;
    logic             out_valid;
    logic             err_short;
    logic             err_long;
    logic             overrun;
    logic             busy;

    pulse_width_decoder #(
        .CNT_W(CNT_W), .MIN_WIDTH(MIN_W), .MAX_WIDTH(MAX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_pulse(in_pulse), .out_ready(out_ready),
        .width_data(width_data), .out_valid(out_valid), .err_short(err_short),
        .err_long(err_long), .overrun(overrun), .busy(busy)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard
    int total = 0;
    int bad = 0;
    logic [CNT_W-1:0] exp_q[$];
    logic [CNT_W-1:0] exp_w;
    int n_res = 0, n_short = 0, n_long = 0, n_ovr = 0;
    int r0, s0, l0, o0;

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (err_short) n_short++;
            if (err_long)  n_long++;
            if (overrun)   n_ovr++;
            if (out_valid && out_ready) begin
                n_res++;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", int'(width_data), -1);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("result_width", int'(width_data), int'(exp_w));
                end
            end
        end
    end

    // Driver tasks
    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(int w, bit ready_on_fall);
        @(posedge clk);
        #1 in_pulse = 1'b1;
        repeat (w) @(posedge clk);
        #1 in_pulse = 1'b0;
        if (ready_on_fall) out_ready = 1'b1;
    endtask

    task automatic snap();
        r0 = n_res; s0 = n_short; l0 = n_long; o0 = n_ovr;
    endtask

    typedef struct {
        int width;
        int exp_res;
        int exp_short;
        int exp_long;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{5,   1, 0, 0};
        vecs[1] = '{1,   0, 1, 0};
        vecs[2] = '{2,   1, 0, 0};
        vecs[3] = '{3,   1, 0, 0};
        vecs[4] = '{200, 1, 0, 0};
        vecs[5] = '{201, 0, 0, 1};
        vecs[6] = '{199, 1, 0, 0};
        vecs[7] = '{13,  1, 0, 0};

        // Reset values, with in_pulse already high
        #12;
        check("rst_width_data", int'(width_data), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_flags", int'({err_short, err_long, overrun}), 0);
        check("rst_busy", int'(busy), 0);

        // Level high through reset release is not a pulse
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(10);
        check("held_high_busy", int'(busy), 0);
        check("held_high_no_result", n_res + n_short + n_long, 0);
        in_pulse  = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back(8'd4);
        snap();
        pulse(4, 1'b0);
        cyc(4);
        check("after_held_result", n_res - r0, 1);

        // Vector table, out_ready held high
        for (int i = 0; i < 8; i++) begin
            snap();
            if (vecs[i].exp_res != 0) exp_q.push_back(CNT_W'(vecs[i].width));
            pulse(vecs[i].width, 1'b0);
            cyc(4);
            check($sformatf("vec%0d_results", i), n_res - r0, vecs[i].exp_res);
            check($sformatf("vec%0d_short", i), n_short - s0, vecs[i].exp_short);
            check($sformatf("vec%0d_long", i), n_long - l0, vecs[i].exp_long);
            check($sformatf("vec%0d_pending", i), exp_q.size(), 0);
        end

        // Random widths around both limits
        for (int i = 0; i < 6; i++) begin
            int w;
            w = $urandom_range(1, 210);
            snap();
            if (w >= MIN_W && w <= MAX_W) exp_q.push_back(CNT_W'(w));
            pulse(w, 1'b0);
            cyc(4);
            check($sformatf("rnd%0d_w%0d_results", i, w), n_res - r0,
                  (w >= MIN_W && w <= MAX_W) ? 1 : 0);
            check($sformatf("rnd%0d_w%0d_short", i, w), n_short - s0, (w < MIN_W) ? 1 : 0);
            check($sformatf("rnd%0d_w%0d_long", i, w), n_long - l0, (w > MAX_W) ? 1 : 0);
        end

        // Nominal latency: result appears at edge k+5 for one cycle
        exp_q.push_back(8'd5);
        @(posedge clk);
        #1 in_pulse = 1'b1;
        repeat (5) @(posedge clk);
        #1 in_pulse = 1'b0;
        @(negedge clk);
        check("nom_valid_early", int'(out_valid), 0);
        check("nom_busy_early", int'(busy), 1);
        @(negedge clk);
        check("nom_valid", int'(out_valid), 1);
        check("nom_width", int'(width_data), 5);
        check("nom_busy_done", int'(busy), 0);
        @(negedge clk);
        check("nom_valid_drop", int'(out_valid), 0);

        // Glitch timing: err_short the cycle after the falling sample
        cyc(2);
        @(posedge clk);
        #1 in_pulse = 1'b1;
        @(posedge clk);
        #1 in_pulse = 1'b0;
        @(negedge clk);
        check("short_early", int'(err_short), 0);
        @(negedge clk);
        check("short_flag", int'(err_short), 1);
        check("short_no_valid", int'(out_valid), 0);
        @(negedge clk);
        check("short_one_cycle", int'(err_short), 0);

        // Overlong: err_long after the 201st high sample, busy until the fall
        cyc(2);
        snap();
        @(posedge clk);
        #1 in_pulse = 1'b1;
        repeat (MAX_W) @(posedge clk);
        @(negedge clk);
        check("long_early", int'(err_long), 0);
        @(negedge clk);
        check("long_flag", int'(err_long), 1);
        @(negedge clk);
        check("long_one_cycle", int'(err_long), 0);
        check("long_busy", int'(busy), 1);
        cyc(3);
        in_pulse = 1'b0;
        @(negedge clk);
        check("long_busy_to_fall", int'(busy), 1);
        @(negedge clk);
        check("long_busy_off", int'(busy), 0);
        cyc(3);
        check("long_no_result", n_res - r0, 0);

        // Backpressure: second result overruns, first is kept
        out_ready = 1'b0;
        snap();
        exp_q.push_back(8'd3);
        pulse(3, 1'b0);
        pulse(7, 1'b0);
        cyc(3);
        check("bp_width_held", int'(width_data), 3);
        check("bp_valid_held", int'(out_valid), 1);
        check("bp_overrun", n_ovr - o0, 1);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_drained", int'(out_valid), 0);
        check("bp_results", n_res - r0, 1);

        // Consume and publish on the same edge
        cyc(1);
        out_ready = 1'b0;
        snap();
        exp_q.push_back(8'd3);
        exp_q.push_back(8'd7);
        pulse(3, 1'b0);
        pulse(7, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("swap_valid", int'(out_valid), 1);
        check("swap_width", int'(width_data), 7);
        cyc(3);
        check("swap_no_overrun", n_ovr - o0, 0);
        check("swap_results", n_res - r0, 2);
        check("swap_drained", int'(out_valid), 0);

        // Reset mid-pulse with a result parked in the slot
        out_ready = 1'b0;
        pulse(4, 1'b0);
        cyc(2);
        check("pre_rst_valid", int'(out_valid), 1);
        @(posedge clk);
        #1 in_pulse = 1'b1;
        cyc(3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_width_data", int'(width_data), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_flags", int'({err_short, err_long, overrun}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        snap();
        cyc(5);
        in_pulse  = 1'b0;
        out_ready = 1'b1;
        cyc(4);
        check("mid_rst_ignored", (n_res - r0) + (n_short - s0) + (n_long - l0), 0);
        check("mid_rst_idle", int'(busy), 0);
        exp_q.push_back(8'd6);
        pulse(6, 1'b0);
        cyc(4);
        check("post_rst_result", n_res - r0, 1);

        // Final drain, bounded
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(1);
        check("exp_q_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
